// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared types and constants for the SPART receive path.
package spart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int   DATA_BITS     = 8;
  localparam logic RX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/spart_sync.sv
// rtl/spart_sync.sv - multi-flop synchronizer for asynchronous single-bit inputs.
module spart_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      ff <= {ff[SYNC_STAGES-2:0], d};
    end
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/spart_rx.sv
// rtl/spart_rx.sv - SPART 8N1 serial receiver with rda/rd_ack handshake.
// SPART_RX_FRAMING_ERR_EN: keep bad-stop frames and flag them on frame_err.
module spart_rx
  import spart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DIV_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxd,
  input  logic [DIV_W-1:0] divisor_buffer,
  input  logic             rd_ack,
  output logic [7:0]       receive_buffer,
  output logic             rda,
  output logic             overrun
`ifdef SPART_RX_FRAMING_ERR_EN
  ,
  output logic             frame_err
`endif
);

  localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rxd_s;
  rx_state_t            state;
  logic [DIV_W-1:0]     div_q;
  logic [DIV_W-1:0]     cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 commit;
  logic                 ack_eff;
`ifdef SPART_RX_FRAMING_ERR_EN
  logic                 commit_bad;
`endif

  spart_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (RX_IDLE_LEVEL)
  ) u_rxd_sync (
    .clk(clk),
    .rst(rst),
    .d  (rxd),
    .q  (rxd_s)
  );

  // An ack only counts while a byte is actually pending.
  assign ack_eff = rd_ack & rda;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      div_q          <= '0;
      cnt            <= '0;
      bit_cnt        <= '0;
      shift_q        <= '0;
      commit         <= 1'b0;
      receive_buffer <= 8'h00;
      rda            <= 1'b0;
      overrun        <= 1'b0;
`ifdef SPART_RX_FRAMING_ERR_EN
      commit_bad     <= 1'b0;
      frame_err      <= 1'b0;
`endif
    end else begin
      commit <= 1'b0;
`ifdef SPART_RX_FRAMING_ERR_EN
      commit_bad <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rxd_s != RX_IDLE_LEVEL) begin
            state <= START;
            div_q <= divisor_buffer;
            cnt   <= divisor_buffer >> 1;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (rxd_s == 1'b0) begin
              state   <= DATA;
              cnt     <= div_q;
              bit_cnt <= 3'd0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shift_q <= {rxd_s, shift_q[DATA_BITS-1:1]};
            cnt     <= div_q;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        STOP: begin
          if (cnt == '0) begin
            if (rxd_s == 1'b1) begin
              commit <= 1'b1;
              state  <= IDLE;
            end else begin
`ifdef SPART_RX_FRAMING_ERR_EN
              commit     <= 1'b1;
              commit_bad <= 1'b1;
`endif
              state <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        WAIT_IDLE: begin
          if (rxd_s == RX_IDLE_LEVEL) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A completing byte wins over an ack; the ack only suppresses overrun.
      if (commit) begin
        receive_buffer <= shift_q;
        rda            <= 1'b1;
        overrun        <= ack_eff ? 1'b0 : (overrun | rda);
`ifdef SPART_RX_FRAMING_ERR_EN
        frame_err      <= commit_bad | (frame_err & ~ack_eff);
`endif
      end else if (ack_eff) begin
        rda     <= 1'b0;
        overrun <= 1'b0;
`ifdef SPART_RX_FRAMING_ERR_EN
        frame_err <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: doc/spart_rx.md
Name: spart_rx

Overview:
- Serial receive half of the SPART; sits directly downstream of the serial line driven by the SPART transmitter (8N1, LSB first, idle high).
- Synchronizes `rxd`, detects the start bit and samples each bit at mid-period.
- Delivers the byte to the bus-interface side with a ready flag (`rda`) and an acknowledge (`rd_ack`).
- Bit period matches the transmitter: divisor_buffer + 1 clk cycles per bit.

Parameters:
- SYNC_STAGES, 2, number of flops in the rxd synchronizer (>=2).
- DIV_W, 16, width of divisor_buffer and baud counter.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- rxd  input  1  asynchronous serial input, idle high
- divisor_buffer  input  DIV_W  baud divisor; bit period P = divisor_buffer+1 clks
- rd_ack  input  1  single-cycle pulse: bus has read receive_buffer
- receive_buffer  output  8  last complete received byte
- rda  output  1  receive data available
- overrun  output  1  sticky: byte completed while rda already 1
- frame_err  output  1  only with SPART_RX_FRAMING_ERR_EN (see below)

Behaviour:
- Reset (async, rst=0):
  - state=IDLE; receive_buffer=8'h00; rda=0; overrun=0; frame_err=0.
  - Synchronizer flops=1; shift reg=0; bit counter=0.
  - Reset mid-frame discards the partial byte.
- rxd_s is the output of a SYNC_STAGES-deep synchronizer. All decisions use rxd_s only.
- div_q latches divisor_buffer on start detection. Divisor changes mid-frame have no effect until the next frame.
- IDLE:
  - rxd_s==0 -> START; load baud counter with div_q>>1 (using the new value).
- START:
  - Counter decrements each clk; sample when counter==0.
  - Sample 0 -> DATA, counter=div_q, bit count=0.
  - Sample 1 -> false start, back to IDLE, nothing reported.
- DATA:
  - Counter reaches 0 -> shift rxd_s into MSB of shift reg (LSB-first arrival), reload div_q, bit count+1.
  - After 8th sample -> STOP.
- STOP:
  - Counter reaches 0 -> sample stop bit.
  - Stop==1: next edge writes receive_buffer <= shift reg, sets rda=1, returns to IDLE.
  - Stop==0 without macro: byte dropped, no flags change, go to WAIT_IDLE.
  - Stop==0 with macro: see Optional Feature.
- WAIT_IDLE:
  - Stay until rxd_s==1, then IDLE. Prevents a break/low line from being read as a stream of start bits.
- Sampling timing: start sampled (div_q>>1)+1 clks after the detect edge; each subsequent bit P clks later.
- divisor_buffer==0: P=1; half count 0 gives a start sample on the cycle after detection.
- rda and rd_ack:
  - rd_ack clears rda on the next edge; it also clears overrun.
  - rd_ack while rda==0 has no effect.
- Simultaneous byte completion and rd_ack: new byte written, rda stays 1, overrun not set.
- Byte completion with rda==1 and no rd_ack: receive_buffer overwritten with the new byte, overrun=1.
- Latency: rda rises 1 clk after the stop-bit sample edge.

Optional Feature:
- Macro: SPART_RX_FRAMING_ERR_EN.
- Defined:
  - A stop sample of 0 sets frame_err=1 (sticky, cleared by rd_ack).
  - The byte is still written to receive_buffer and rda=1, so software sees the bad byte.
  - State goes to WAIT_IDLE.
- Undefined:
  - frame_err port absent.
  - Bad frames are silently dropped.

Decomposition:
- spart_pkg holds:
  - typedef enum rx_state_t {IDLE, START, DATA, STOP, WAIT_IDLE};
  - localparam DATA_BITS=8;
  - localparam RX_IDLE_LEVEL=1'b1.
- One sub-module: spart_sync (parameterized SYNC_STAGES, reset value 1) for rxd. It is reused for any other async inputs.

Test Plan:
- divisor=4 (P=5); drive 8N1 frame 0xA5 with 5-clk bits -> rda rises 1 clk after stop sample; receive_buffer=8'hA5; overrun=0.
- Glitch rxd low 2 clks with divisor=9 (half=4) -> false start; rda stays 0; back to IDLE; next frame 0x3C received correctly.
- Send 0x11 then 0x22 with no rd_ack -> receive_buffer=8'h22, rda=1, overrun=1. rd_ack pulse -> rda=0, overrun=0.
- rd_ack asserted on the exact cycle 0x55 completes (rda=1 from prior byte) -> rda=1, receive_buffer=8'h55, overrun=0.
- Frame 0x7E with stop bit=0, divisor=2:
  - Macro off -> no rda; line held low 30 clks then high -> no spurious bytes.
  - Macro on -> rda=1, receive_buffer=8'h7E, frame_err=1.
- Assert rst low during DATA bit 4 of 0xF0, release, send 0x0F -> outputs zero during reset; receive_buffer=8'h0F; no overrun.
